unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the fetch stage (instruction reads) and the memory stage (data loads and stores).
- Sits between the two pipeline stages and the memory model.
- Produces per-requester stall signals that feed the hazard unit alongside its existing StallF/StallD logic.
- Data requests have priority, with a starvation guard so fetch is still serviced.

Parameters:
WORD_SIZE, 32, data width (matches the `WORD_SIZE define)
ADDR_W, 32, address width
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; 0 means pure data priority

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch read request; held until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  WORD_SIZE  instruction word, valid with if_valid
if_valid  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  WORD_SIZE  store data
dm_rdata  out  WORD_SIZE  load data, valid with dm_valid
dm_valid  out  1  one-cycle completion pulse for data
stall_if  out  1  if_req & ~if_valid (combinational)
stall_dm  out  1  dm_req & ~dm_valid (combinational)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  WORD_SIZE  memory write data
mem_ack  in  1  one-cycle pulse; memory has completed the access, and mem_rdata is valid for reads
mem_rdata  in  WORD_SIZE  memory read data

Behaviour:
- All outputs except stall_if and stall_dm are registered.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0, starve_cnt=0, state=IDLE.
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE: arbitrate on the sampled requests.
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data, unless STARVE_LIMIT!=0 and starve_cnt==STARVE_LIMIT, in which case grant fetch.
  - None: stay in IDLE.
- On grant in cycle N:
  - Latch address/we/wdata into the mem_* registers.
  - mem_req is high from cycle N+1.
  - Fetch grants force mem_we=0.
- BUSY_x: hold mem_req and all mem_* fields stable until mem_ack.
- mem_ack in cycle M:
  - Clear mem_req at M+1.
  - Go to RESP at M+1 and pulse x_valid at M+1.
  - Reads capture mem_rdata into x_rdata at M+1.
  - Stores pulse dm_valid but leave dm_rdata unchanged.
- RESP: unconditionally go to IDLE.
  - Requests are not sampled in RESP, so a requester still holding req during its valid cycle is not re-granted.
  - A new transaction can start in IDLE at M+2, with mem_req high at M+3.
- Minimum latency: grant at N, mem_ack at N+1, valid at N+2.
- x_rdata holds its value between valid pulses.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each data grant made while if_req=1.
  - It clears on any fetch grant.
  - It is unchanged when data is granted with if_req=0.
- mem_ack outside BUSY states is ignored.
- Requester rules:
  - Deasserting req, or changing its fields, before valid is a protocol violation; behaviour is undefined.
  - Fields are latched at grant, so the memory sees a stable request.
- Reset mid-transaction abandons the access.
  - mem_req drops at the next edge.
  - No valid pulse is issued.
  - The memory model must discard the outstanding access.
- Simultaneous rst and mem_ack: rst wins.

Decomposition:
- constants.v gains:
  - state encodings MEMARB_IDLE/BUSY_IF/BUSY_DM/RESP (2 bits);
  - default STARVE_LIMIT.
- The arbitration decision (inputs: if_req, dm_req, starve_cnt; output: grant vector) goes in sub-module mem_arb_pick, which is combinational and unit-testable.
- All state, registers and the counter stay in unified_mem_arbiter.

Test Plan:
1. Isolated fetch: if_req=1, if_addr=0x10; memory acks 2 cycles after mem_req with 0x00500093 -> mem_req high from N+1 with mem_addr=0x10, mem_we=0; if_valid pulses once with if_rdata=0x00500093; stall_if=1 until that cycle.
2. Simultaneous requests: if_req and dm_req (store 0xDEADBEEF to 0x100) in the same cycle -> store issued first (mem_we=1, mem_wdata=0xDEADBEEF); fetch issues after RESP; dm_rdata unchanged.
3. Starvation: STARVE_LIMIT=2, dm_req reasserted continuously with new addresses, if_req held -> grant order DM, DM, IF, DM, DM, IF.
4. Back-to-back fetch holding req through RESP -> exactly one if_valid per transaction; next mem_req rises at M+3, never at M+2.
5. Reset mid-op: rst asserted in a BUSY_DM cycle -> next edge mem_req=0, state=IDLE, no dm_valid; an ack one cycle later is ignored.
6. Load: dm_req with dm_we=0, addr 0x200; memory returns 0x12345678 -> dm_valid pulse with dm_rdata=0x12345678; the value holds after the pulse.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package unified_mem_arbiter_pkg;

    // Arbiter FSM encodings (2 bits)
    typedef enum logic [1:0] {
        MEMARB_IDLE    = 2'd0,
        MEMARB_BUSY_IF = 2'd1,
        MEMARB_BUSY_DM = 2'd2,
        MEMARB_RESP    = 2'd3
    } memArbState_t;

    // Default number of back-to-back data grants tolerated while fetch waits
    localparam int MEMARB_STARVE_LIMIT = 4;

    // One-hot-or-zero grant vector produced by the pick logic
    typedef struct packed {
        logic fetch;
        logic data;
    } memArbGrant_t;

    // Counter width able to hold 0..limit; never narrower than one bit
    function automatic int starveCntWidth(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_pick.sv
// Arbitration decision between fetch and data requesters (data first, starvation guard).
// Latency: purely combinational.
// Backpressure: none; caller only acts on the grant while idle.
//
// Ports:
//   ifReq     - fetch request
//   dmReq     - data request
//   starveCnt - data grants made while fetch was waiting
//   grant     - at most one of {fetch, data} set
module mem_arb_pick
    import unified_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = MEMARB_STARVE_LIMIT,
    localparam int CNT_W = starveCntWidth(STARVE_LIMIT)
) (
    input  logic             ifReq,
    input  logic             dmReq,
    input  logic [CNT_W-1:0] starveCnt,
    output memArbGrant_t     grant
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic fetchTurn;

    always_comb begin
        // A zero limit disables the guard entirely: data always wins a tie
        fetchTurn = (STARVE_LIMIT != 0) && (starveCnt == STARVE_MAX);
        grant     = '0;
        if (dmReq && !(ifReq && fetchTurn)) begin
            grant.data = 1'b1;
        end else if (ifReq) begin
            grant.fetch = 1'b1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported variable-latency memory between fetch and data stages.
// Latency: grant at N, mem_req at N+1, earliest valid at N+2; one RESP cycle between accesses.
// Backpressure: requesters hold req until their valid pulse; stall_x = req & ~valid.
//
// Ports:
//   clk, rst                              - clock, synchronous active-high reset
//   if_req/if_addr/if_rdata/if_valid       - fetch read channel
//   dm_req/dm_we/dm_addr/dm_wdata/dm_rdata/dm_valid - data load/store channel
//   stall_if, stall_dm                    - combinational stalls to the hazard unit
//   mem_req/mem_we/mem_addr/mem_wdata     - registered request to memory, held until mem_ack
//   mem_ack/mem_rdata                     - memory completion pulse and read data
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = MEMARB_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic [WORD_SIZE-1:0] if_rdata,
    output logic                 if_valid,

    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [ADDR_W-1:0]    dm_addr,
    input  logic [WORD_SIZE-1:0] dm_wdata,
    output logic [WORD_SIZE-1:0] dm_rdata,
    output logic                 dm_valid,

    output logic                 stall_if,
    output logic                 stall_dm,

    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    localparam int               CNT_W      = starveCntWidth(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    memArbState_t     state;
    memArbState_t     stateNext;
    logic [CNT_W-1:0] starveCnt;
    memArbGrant_t     grant;

    logic grantIf;
    logic grantDm;
    logic ackIf;
    logic ackDm;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .ifReq     (if_req),
        .dmReq     (dm_req),
        .starveCnt (starveCnt),
        .grant     (grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEMARB_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; RESP never looks at requests so a held req is not re-granted
    always_comb begin
        stateNext = state;
        unique case (state)
            MEMARB_IDLE: begin
                if (grant.data) begin
                    stateNext = MEMARB_BUSY_DM;
                end else if (grant.fetch) begin
                    stateNext = MEMARB_BUSY_IF;
                end
            end
            MEMARB_BUSY_IF,
            MEMARB_BUSY_DM: begin
                if (mem_ack) begin
                    stateNext = MEMARB_RESP;
                end
            end
            MEMARB_RESP: stateNext = MEMARB_IDLE;
            default:     stateNext = MEMARB_IDLE;
        endcase
    end

    // Control strobes; mem_ack outside the busy states falls through unused
    always_comb begin
        grantIf = (state == MEMARB_IDLE) && grant.fetch;
        grantDm = (state == MEMARB_IDLE) && grant.data;
        ackIf   = (state == MEMARB_BUSY_IF) && mem_ack;
        ackDm   = (state == MEMARB_BUSY_DM) && mem_ack;
    end

    // Registered datapath, response pulses and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            starveCnt <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;

            // Fields are captured once at grant so memory sees a stable request
            if (grantDm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grantIf) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end

            if (ackIf) begin
                mem_req  <= 1'b0;
                if_valid <= 1'b1;
                if_rdata <= mem_rdata;
            end

            if (ackDm) begin
                mem_req  <= 1'b0;
                dm_valid <= 1'b1;
                // Stores complete without disturbing the last load result
                if (!mem_we) begin
                    dm_rdata <= mem_rdata;
                end
            end

            // Only data grants that actually made fetch wait are counted
            if (grantIf) begin
                starveCnt <= '0;
            end else if (grantDm && if_req && (starveCnt != STARVE_MAX)) begin
                starveCnt <= starveCnt + 1'b1;
            end
        end
    end

    assign stall_if = if_req & ~if_valid;
    assign stall_dm = dm_req & ~dm_valid;

endmodule
